// File: rtl/host_launch_ctrl.sv
// Host-side kernel launch sequencer: programs the DCR thread count, pulses
// gpu_start, watches gpu_done with a watchdog, and recovers via GPU soft reset.
module host_launch_ctrl #(
  parameter int unsigned DATA_BITS       = 8,
  parameter int unsigned TIMEOUT_BITS    = 16,
  parameter int unsigned DEFAULT_TIMEOUT = 200,
  parameter int unsigned RECOVER_CYCLES  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    host_cmd_valid,
  output logic                    host_cmd_ready,
  input  logic [1:0]              host_cmd_op,
  input  logic [TIMEOUT_BITS-1:0] host_cmd_data,
  output logic                    dcr_write_enable,
  output logic [DATA_BITS-1:0]    dcr_data,
  output logic                    gpu_start,
  output logic                    gpu_reset,
  input  logic                    gpu_done,
  output logic                    busy,
  output logic                    done_flag,
  output logic                    timeout_flag,
  output logic                    abort_flag,
  output logic                    err_flag,
  output logic [TIMEOUT_BITS-1:0] cycle_count,
  output logic                    irq
);

  localparam int unsigned REC_W = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;

  localparam logic [1:0] OP_SET_THREADS = 2'b00;
  localparam logic [1:0] OP_SET_TIMEOUT = 2'b01;
  localparam logic [1:0] OP_LAUNCH      = 2'b10;
  localparam logic [1:0] OP_ABORT       = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CFG     = 3'd1,
    S_START   = 3'd2,
    S_RUN     = 3'd3,
    S_RECOVER = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [DATA_BITS-1:0]    thread_q, thread_d;
  logic [TIMEOUT_BITS-1:0] timeout_q, timeout_d;
  logic [TIMEOUT_BITS-1:0] run_limit_q, run_limit_d;
  logic [TIMEOUT_BITS-1:0] cycle_count_q, cycle_count_d;
  logic [REC_W-1:0]        rec_cnt_q, rec_cnt_d;
  logic [DATA_BITS-1:0]    dcr_data_q, dcr_data_d;
  logic                    dcr_we_q, dcr_we_d;
  logic                    gpu_start_q, gpu_start_d;
  logic                    gpu_reset_q, gpu_reset_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    timeout_flag_q, timeout_flag_d;
  logic                    abort_q, abort_d;
  logic                    err_q, err_d;
  logic                    irq_q, irq_d;

  logic                    cmd_acc;
  logic                    abort_acc;
  logic                    timeout_hit;
  logic                    rec_last;
  logic [TIMEOUT_BITS-1:0] cnt_inc;
  logic [TIMEOUT_BITS-1:0] cnt_sat;

  assign host_cmd_ready = (state_q == S_IDLE) || (state_q == S_RUN);
  assign cmd_acc        = host_cmd_valid && host_cmd_ready;
  assign abort_acc      = cmd_acc && (host_cmd_op == OP_ABORT);
  assign cnt_inc        = cycle_count_q + TIMEOUT_BITS'(1);
  assign cnt_sat        = (&cycle_count_q) ? cycle_count_q : cnt_inc;
  // A zero run_limit disables the watchdog; the +1 compare ends RUN after exactly L cycles.
  assign timeout_hit    = (run_limit_q != '0) && (cnt_inc == run_limit_q);
  assign rec_last       = (rec_cnt_q == REC_W'(RECOVER_CYCLES - 1));

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_RECOVER;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_acc && (host_cmd_op == OP_LAUNCH) && (thread_q != '0)) state_d = S_CFG;
      end
      S_CFG:   state_d = S_START;
      S_START: state_d = S_RUN;
      S_RUN: begin
        if (gpu_done)         state_d = S_IDLE;
        else if (abort_acc)   state_d = S_RECOVER;
        else if (timeout_hit) state_d = S_RECOVER;
      end
      S_RECOVER: begin
        if (rec_last) state_d = S_IDLE;
      end
      default: state_d = S_RECOVER;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    thread_d       = thread_q;
    timeout_d      = timeout_q;
    run_limit_d    = run_limit_q;
    cycle_count_d  = cycle_count_q;
    dcr_data_d     = dcr_data_q;
    done_d         = done_q;
    timeout_flag_d = timeout_flag_q;
    abort_d        = abort_q;
    err_d          = err_q;
    rec_cnt_d      = '0;
    dcr_we_d       = (state_d == S_CFG);
    gpu_start_d    = (state_d == S_START);
    gpu_reset_d    = (state_d == S_RECOVER);
    busy_d         = (state_d != S_IDLE);
    irq_d          = (state_q == S_RUN) && (state_d != S_RUN);

    if ((state_q == S_RECOVER) && (state_d == S_RECOVER)) rec_cnt_d = rec_cnt_q + REC_W'(1);

    unique case (state_q)
      S_IDLE: begin
        if (cmd_acc) begin
          unique case (host_cmd_op)
            OP_SET_THREADS: thread_d  = host_cmd_data[DATA_BITS-1:0];
            OP_SET_TIMEOUT: timeout_d = host_cmd_data;
            OP_LAUNCH: begin
              if (thread_q == '0) begin
                err_d = 1'b1;
              end else begin
                done_d         = 1'b0;
                timeout_flag_d = 1'b0;
                abort_d        = 1'b0;
                err_d          = 1'b0;
                cycle_count_d  = '0;
                run_limit_d    = timeout_q;
                dcr_data_d     = thread_q;
              end
            end
            default: ;
          endcase
        end
      end
      S_RUN: begin
        // Configuration and launch commands are refused while a kernel runs.
        if (cmd_acc && (host_cmd_op != OP_ABORT)) err_d = 1'b1;
        if (gpu_done) begin
          cycle_count_d = cnt_sat;
          done_d        = 1'b1;
        end else if (abort_acc) begin
          cycle_count_d = cnt_sat;
          abort_d       = 1'b1;
        end else if (timeout_hit) begin
          cycle_count_d  = run_limit_q;
          timeout_flag_d = 1'b1;
        end else begin
          cycle_count_d = cnt_sat;
        end
      end
      default: ;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      thread_q       <= '0;
      timeout_q      <= TIMEOUT_BITS'(DEFAULT_TIMEOUT);
      run_limit_q    <= TIMEOUT_BITS'(DEFAULT_TIMEOUT);
      cycle_count_q  <= '0;
      rec_cnt_q      <= '0;
      dcr_data_q     <= '0;
      dcr_we_q       <= 1'b0;
      gpu_start_q    <= 1'b0;
      gpu_reset_q    <= 1'b1;
      busy_q         <= 1'b1;
      done_q         <= 1'b0;
      timeout_flag_q <= 1'b0;
      abort_q        <= 1'b0;
      err_q          <= 1'b0;
      irq_q          <= 1'b0;
    end else begin
      thread_q       <= thread_d;
      timeout_q      <= timeout_d;
      run_limit_q    <= run_limit_d;
      cycle_count_q  <= cycle_count_d;
      rec_cnt_q      <= rec_cnt_d;
      dcr_data_q     <= dcr_data_d;
      dcr_we_q       <= dcr_we_d;
      gpu_start_q    <= gpu_start_d;
      gpu_reset_q    <= gpu_reset_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      timeout_flag_q <= timeout_flag_d;
      abort_q        <= abort_d;
      err_q          <= err_d;
      irq_q          <= irq_d;
    end
  end

  assign dcr_write_enable = dcr_we_q;
  assign dcr_data         = dcr_data_q;
  assign gpu_start        = gpu_start_q;
  assign gpu_reset        = gpu_reset_q;
  assign busy             = busy_q;
  assign done_flag        = done_q;
  assign timeout_flag     = timeout_flag_q;
  assign abort_flag       = abort_q;
  assign err_flag         = err_q;
  assign cycle_count      = cycle_count_q;
  assign irq              = irq_q;

endmodule

// File: tb/tb_host_launch_ctrl.sv
// Bench for host_launch_ctrl: directed and random launches against a
// launch-level outcome model (earliest of done / abort / timeout).
module tb_host_launch_ctrl;

  localparam int unsigned DW = 8;
  localparam int unsigned TW = 16;
  localparam int unsigned RC = 2;

  localparam logic [1:0] OP_SET_THREADS = 2'b00;
  localparam logic [1:0] OP_SET_TIMEOUT = 2'b01;
  localparam logic [1:0] OP_LAUNCH      = 2'b10;
  localparam logic [1:0] OP_ABORT       = 2'b11;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          host_cmd_valid = 1'b0;
  logic          host_cmd_ready;
  logic [1:0]    host_cmd_op = 2'b00;
  logic [TW-1:0] host_cmd_data = '0;
  logic          dcr_write_enable;
  logic [DW-1:0] dcr_data;
  logic          gpu_start;
  logic          gpu_reset;
  logic          gpu_done = 1'b0;
  logic          busy;
  logic          done_flag, timeout_flag, abort_flag, err_flag;
  logic [TW-1:0] cycle_count;
  logic          irq;

  int checks = 0;
  int errors = 0;

  // Launch-level model state
  int m_thr = 0;
  int m_to  = 200;
  int m_cnt = 0;
  bit m_done = 0, m_tof = 0, m_ab = 0, m_err = 0;

  int mon_dcr = 0, mon_start = 0, mon_irq = 0;

  host_launch_ctrl #(
    .DATA_BITS(DW), .TIMEOUT_BITS(TW), .DEFAULT_TIMEOUT(200), .RECOVER_CYCLES(RC)
  ) dut (
    .clk(clk), .reset(reset),
    .host_cmd_valid(host_cmd_valid), .host_cmd_ready(host_cmd_ready),
    .host_cmd_op(host_cmd_op), .host_cmd_data(host_cmd_data),
    .dcr_write_enable(dcr_write_enable), .dcr_data(dcr_data),
    .gpu_start(gpu_start), .gpu_reset(gpu_reset), .gpu_done(gpu_done),
    .busy(busy), .done_flag(done_flag), .timeout_flag(timeout_flag),
    .abort_flag(abort_flag), .err_flag(err_flag),
    .cycle_count(cycle_count), .irq(irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (dcr_write_enable) mon_dcr++;
    if (gpu_start)        mon_start++;
    if (irq)              mon_irq++;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [TW-1:0] d);
    int n;
    n = 0;
    host_cmd_op    = op;
    host_cmd_data  = d;
    host_cmd_valid = 1'b1;
    while (!host_cmd_ready && n < 50) begin
      step();
      n++;
    end
    if (!host_cmd_ready) begin
      check_eq("cmd_accept_wait", 32'(0), 32'(1));
      host_cmd_valid = 1'b0;
      return;
    end
    step();
    host_cmd_valid = 1'b0;
  endtask

  task automatic set_threads(input int v);
    logic [TW-1:0] d;
    d = TW'($urandom);
    d[DW-1:0] = DW'(v);
    send_cmd(OP_SET_THREADS, d);
    m_thr = v;
  endtask

  task automatic set_timeout(input int v);
    send_cmd(OP_SET_TIMEOUT, TW'(v));
    m_to = v;
  endtask

  task automatic check_flags(input string tag);
    check_eq({tag, "_done_flag"},    32'(done_flag),    32'(m_done));
    check_eq({tag, "_timeout_flag"}, 32'(timeout_flag), 32'(m_tof));
    check_eq({tag, "_abort_flag"},   32'(abort_flag),   32'(m_ab));
    check_eq({tag, "_err_flag"},     32'(err_flag),     32'(m_err));
    check_eq({tag, "_cycle_count"},  32'(cycle_count),  32'(m_cnt));
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_gpu_reset"}, 32'(gpu_reset),        32'(1));
    check_eq({tag, "_busy"},      32'(busy),             32'(1));
    check_eq({tag, "_ready"},     32'(host_cmd_ready),   32'(0));
    check_eq({tag, "_dcr_we"},    32'(dcr_write_enable), 32'(0));
    check_eq({tag, "_gpu_start"}, 32'(gpu_start),        32'(0));
    check_eq({tag, "_irq"},       32'(irq),              32'(0));
    check_eq({tag, "_dcr_data"},  32'(dcr_data),         32'(0));
    check_flags(tag);
  endtask

  // Counts gpu_reset-high cycles until the controller is ready again.
  task automatic wait_recover(input string tag);
    int n, hi;
    n  = 0;
    hi = 0;
    while (!host_cmd_ready && n < 20) begin
      if (gpu_reset) hi++;
      step();
      n++;
    end
    check_eq({tag, "_recover_cycles"}, 32'(hi), 32'(RC));
    check_eq({tag, "_ready_after"},    32'(host_cmd_ready), 32'(1));
    check_eq({tag, "_gpu_reset_off"},  32'(gpu_reset), 32'(0));
  endtask

  // done_at/abort_at/set_at: RUN cycle of the event, 0 = never.
  task automatic do_launch(input int done_at, input int abort_at, input int set_at,
                           input logic [1:0] set_op, input string tag);
    int    e, b_dcr, b_start, b_irq;
    string kind;
    bit    err_exp;
    b_dcr   = mon_dcr;
    b_start = mon_start;
    b_irq   = mon_irq;
    if (m_thr == 0) begin
      send_cmd(OP_LAUNCH, TW'($urandom));
      m_err = 1;
      repeat (3) step();
      check_eq({tag, "_zero_busy"},  32'(busy), 32'(0));
      check_eq({tag, "_zero_dcr"},   32'(mon_dcr - b_dcr), 32'(0));
      check_eq({tag, "_zero_start"}, 32'(mon_start - b_start), 32'(0));
      check_eq({tag, "_zero_irq"},   32'(mon_irq - b_irq), 32'(0));
      check_flags({tag, "_zero"});
      return;
    end
    e    = 1 << 30;
    kind = "none";
    if (done_at != 0)                  begin e = done_at;  kind = "done";    end
    if (abort_at != 0 && abort_at < e) begin e = abort_at; kind = "abort";   end
    if (m_to != 0 && m_to < e)         begin e = m_to;     kind = "timeout"; end
    err_exp = (set_at != 0) && (set_at <= e) && (set_at != abort_at);

    send_cmd(OP_LAUNCH, TW'($urandom));
    check_eq({tag, "_dcr_we"},   32'(dcr_write_enable), 32'(1));
    check_eq({tag, "_dcr_data"}, 32'(dcr_data), 32'(m_thr));
    step();
    check_eq({tag, "_gpu_start"}, 32'(gpu_start), 32'(1));
    step();
    for (int k = 1; k <= e; k++) begin
      gpu_done = (k == done_at);
      if (k == abort_at) begin
        host_cmd_valid = 1'b1;
        host_cmd_op    = OP_ABORT;
      end else if (k == set_at) begin
        host_cmd_valid = 1'b1;
        host_cmd_op    = set_op;
        host_cmd_data  = TW'($urandom);
      end else begin
        host_cmd_valid = 1'b0;
      end
      step();
    end
    gpu_done       = 1'b0;
    host_cmd_valid = 1'b0;

    m_done = (kind == "done");
    m_ab   = (kind == "abort");
    m_tof  = (kind == "timeout");
    m_err  = err_exp;
    m_cnt  = e;
    check_eq({tag, "_irq"}, 32'(irq), 32'(1));
    check_flags(tag);
    check_eq({tag, "_busy_end"},      32'(busy),      32'(kind != "done"));
    check_eq({tag, "_gpu_reset_end"}, 32'(gpu_reset), 32'(kind != "done"));
    if (kind != "done") wait_recover(tag);
    else check_eq({tag, "_ready_end"}, 32'(host_cmd_ready), 32'(1));
    step();
    check_eq({tag, "_irq_low"},     32'(irq), 32'(0));
    check_eq({tag, "_dcr_pulses"},  32'(mon_dcr - b_dcr), 32'(1));
    check_eq({tag, "_start_pulses"},32'(mon_start - b_start), 32'(1));
    check_eq({tag, "_irq_pulses"},  32'(mon_irq - b_irq), 32'(1));
  endtask

  initial begin
    #1 reset = 1'b0;
    #2 check_reset_vals("por");
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    wait_recover("por");

    do_launch(0, 0, 0, OP_SET_THREADS, "zero_threads");
    set_threads(8);
    do_launch(5, 0, 0, OP_SET_THREADS, "done5");
    set_timeout(10);
    do_launch(0, 0, 0, OP_SET_THREADS, "timeout10");
    set_timeout(200);
    do_launch(0, 3, 0, OP_SET_THREADS, "abort3");
    set_timeout(6);
    do_launch(0, 0, 2, OP_SET_TIMEOUT, "set_in_run");
    set_timeout(0);
    do_launch(300, 0, 0, OP_SET_THREADS, "no_timeout300");
    set_timeout(4);
    do_launch(4, 0, 0, OP_SET_THREADS, "done_vs_timeout");
    do_launch(3, 3, 0, OP_SET_THREADS, "done_vs_abort");
    do_launch(0, 4, 0, OP_SET_THREADS, "abort_vs_timeout");

    for (int i = 0; i < 25; i++) begin
      int thr, lim, d, a, s;
      logic [1:0] sop;
      thr = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 255));
      set_threads(thr);
      lim = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 20));
      set_timeout(lim);
      if ($urandom_range(0, 3) == 0) send_cmd(OP_ABORT, TW'($urandom));
      d   = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 25));
      a   = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 25));
      s   = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 25));
      sop = 2'($urandom_range(0, 2));
      if (lim == 0 && d == 0 && a == 0) d = int'($urandom_range(1, 25));
      if (s == a) s = 0;
      do_launch(d, a, s, sop, "rnd");
    end

    // Asynchronous reset in the middle of a run
    set_threads(5);
    set_timeout(0);
    send_cmd(OP_LAUNCH, '0);
    repeat (4) step();
    #2 reset = 1'b0;
    #1;
    m_thr = 0; m_to = 200; m_cnt = 0;
    m_done = 0; m_tof = 0; m_ab = 0; m_err = 0;
    check_reset_vals("midrun_rst");
    @(negedge clk) reset = 1'b1;
    wait_recover("midrun_rst");
    do_launch(0, 0, 0, OP_SET_THREADS, "post_rst_zero");
    set_threads(3);
    do_launch(0, 0, 0, OP_SET_THREADS, "post_rst_default_to");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/host_launch_ctrl.md
# host_launch_ctrl

Host-side kernel launch sequencer that sits directly upstream of the miniGPU top level. It takes launch commands from a host port, programs the thread count into the device control register, pulses the GPU start input, and monitors kernel completion. It enforces a watchdog timeout and a host abort, both recovered by a soft reset of the GPU. It reports done, timeout, abort, error and elapsed-cycle status back to the host, replacing bench-only start/wait/timeout stimulus with synthesizable hardware.

## Interface
Parameters:
- DATA_BITS, 8, width of the thread count written to the DCR.
- TIMEOUT_BITS, 16, width of the timeout register and cycle counter.
- DEFAULT_TIMEOUT, 200, timeout register reset value, in clk cycles.
- RECOVER_CYCLES, 2, number of cycles gpu_reset is held during recovery.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low; 0 = in reset.
- host_cmd_valid  in  1  command valid.
- host_cmd_ready  out  1  command accepted when valid && ready at a rising edge.
- host_cmd_op  in  2  command opcode: 00 SET_THREADS, 01 SET_TIMEOUT, 10 LAUNCH, 11 ABORT.
- host_cmd_data  in  TIMEOUT_BITS  command operand; SET_THREADS uses the low DATA_BITS.
- dcr_write_enable  out  1  one-cycle DCR write strobe.
- dcr_data  out  DATA_BITS  thread count to the DCR.
- gpu_start  out  1  one-cycle start pulse to the GPU.
- gpu_reset  out  1  active-high soft reset to the GPU.
- gpu_done  in  1  kernel-complete level from the GPU.
- busy  out  1  high in every state except IDLE.
- done_flag, timeout_flag, abort_flag, err_flag  out  1 each  sticky status bits.
- cycle_count  out  TIMEOUT_BITS  number of RUN cycles in the last launch.
- irq  out  1  one-cycle pulse when a launch ends.

## Operation
- States: IDLE, CFG, START, RUN, RECOVER. Reset enters RECOVER with the recovery counter at 0, so the GPU is held in reset.
- host_cmd_ready is 1 in IDLE and RUN, and 0 in CFG, START and RECOVER.
- In IDLE:
  - SET_THREADS loads thread_reg.
  - SET_TIMEOUT loads timeout_reg.
  - ABORT is a no-op.
  - LAUNCH with thread_reg == 0 sets err_flag and stays in IDLE.
  - LAUNCH with thread_reg != 0 clears all four flags, clears cycle_count, latches run_limit = timeout_reg, and moves to CFG.
- CFG: dcr_write_enable = 1 and dcr_data = thread_reg. Moves to START.
- START: gpu_start = 1. Moves to RUN.
- RUN, evaluated each cycle in this priority order:
  1. gpu_done = 1: cycle_count += 1, set done_flag, go to IDLE.
  2. Accepted ABORT: cycle_count += 1, set abort_flag, go to RECOVER.
  3. run_limit != 0 and cycle_count + 1 == run_limit: cycle_count = run_limit, set timeout_flag, go to RECOVER.
  4. Otherwise cycle_count += 1, saturating at all-ones.
- Accepted SET_THREADS, SET_TIMEOUT or LAUNCH in RUN are dropped and set err_flag. A SET_* in RUN does not alter thread_reg, timeout_reg or run_limit.
- run_limit = 0 disables the timeout.
- RECOVER: gpu_reset = 1 for RECOVER_CYCLES cycles, then go to IDLE.
- gpu_done is ignored outside RUN.
- irq pulses for one cycle, in the cycle after RUN exits for any reason. The lengthened "RUN exit" is needed because RUN can exit via done, abort or timeout.

## Timing
- Reset values (while reset = 0):
  - state RECOVER; gpu_reset = 1, busy = 1.
  - host_cmd_ready = 0, dcr_write_enable = 0, gpu_start = 0, irq = 0.
  - all flags 0, cycle_count = 0, dcr_data = 0.
  - thread_reg = 0, timeout_reg = DEFAULT_TIMEOUT.
- After reset release, gpu_reset stays high for RECOVER_CYCLES cycles. host_cmd_ready rises in the following cycle.
- All outputs are registered, except host_cmd_ready, which is decoded from state.
- LAUNCH accepted at edge T:
  - dcr_write_enable is high during cycle T+1.
  - gpu_start is high during cycle T+2.
  - The first RUN cycle is T+3.
- If gpu_done is first seen in the k-th RUN cycle:
  - done_flag = 1, cycle_count = k and busy = 0 in the next cycle.
  - irq is high in that same next cycle.
- Timeout with run_limit = L: exactly L RUN cycles, then RECOVER. cycle_count = L.
- gpu_done and timeout in the same cycle: done wins, timeout_flag stays 0.
- gpu_done and ABORT in the same cycle: done wins, and the ABORT is consumed with no effect.
- Asynchronous reset mid-RUN: immediate return to the reset state and values; flags and cycle_count are lost.

## Test plan
- Reset, SET_THREADS 8, LAUNCH; gpu_done rises in RUN cycle 5 -> dcr_write_enable and dcr_data = 8 for 1 cycle, gpu_start 1 cycle later, done_flag = 1, cycle_count = 5, one irq pulse, busy = 0.
- SET_TIMEOUT 10, LAUNCH, gpu_done held 0 -> timeout_flag = 1, cycle_count = 10, gpu_reset high for exactly 2 cycles, then ready = 1.
- LAUNCH, ABORT accepted in RUN cycle 3 -> abort_flag = 1, cycle_count = 3, 2-cycle gpu_reset, irq pulse, done_flag = 0.
- LAUNCH with thread_reg = 0 -> err_flag = 1, no dcr_write_enable, no gpu_start, busy stays 0. SET_TIMEOUT in RUN -> err_flag = 1, run_limit unchanged.
- SET_TIMEOUT 0, gpu_done after 300 cycles -> no timeout, cycle_count = 300. gpu_done and timeout coincide at L = 4 -> done_flag = 1, timeout_flag = 0.
- reset driven to 0 during RUN -> all outputs immediately at reset values; after release, gpu_reset held 2 cycles, then IDLE.
